// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing constants: preamble cell patterns and subframe slot map.
// Used by both spdif_encoder and spdif_decoder.
package spdif_pkg;

    // Preamble cell patterns, first cell in the MSB, defined for a preceding line level of 0
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam int SLOT_AUX0        = 4;
    localparam int SLOT_V           = 28;
    localparam int SLOT_U           = 29;
    localparam int SLOT_C           = 30;
    localparam int SLOT_P           = 31;
    localparam int FRAMES_PER_BLOCK = 192;

    typedef enum logic {
        SUB_L = 1'b0,
        SUB_R = 1'b1
    } subframe_e;

    function automatic logic [7:0] preamble_for(input subframe_e sub, input logic block_start);
        if (sub == SUB_R) begin
            return PRE_W;
        end
        return block_start ? PRE_B : PRE_M;
    endfunction

endpackage

// File: rtl/spdif_nco.sv
// Phase-accumulator NCO: the carry out of each addition is one biphase cell tick.
// Synchronous clear zeroes the phase and suppresses the tick in that cycle.
module spdif_nco #(
    parameter int ACC_W     = 24,
    parameter int PHASE_INC = 1937579
) (
    input  logic clk_in,
    input  logic clear,
    output logic tick
);

    localparam logic [ACC_W-1:0] INC = ACC_W'(PHASE_INC);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_reg} + {1'b0, INC};
    assign tick    = acc_sum[ACC_W] & ~clear;

    always_ff @(posedge clk_in) begin
        if (clear) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/spdif_encoder.sv
// S/PDIF transmitter: holding register + handshake, 192-frame block framer,
// subframe slot mux with parity, and a registered biphase-mark line driver.
module spdif_encoder
    import spdif_pkg::*;
#(
    parameter int          ACC_W     = 24,
    parameter int          PHASE_INC = 1937579,
    parameter logic [39:0] CS_LO     = 40'h0
) (
    input  logic        clk_in,
    input  logic        resetb,
    input  logic        tx_enable,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        tx_out,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [63:0] CS_EXT = {24'h0, CS_LO};

    logic        run;
    logic        nco_clear;
    logic        tick;

    logic        hold_full_reg;
    logic [23:0] hold_l_reg;
    logic [23:0] hold_r_reg;
    logic [23:0] l_reg;
    logic [23:0] r_reg;
    logic        v_reg;

    logic        cell_reg;
    logic [4:0]  slot_reg;
    subframe_e   sub_reg;
    logic [7:0]  frame_reg;

    logic        tx_out_reg;
    logic        pre_inv_reg;
    logic        frame_start_reg;
    logic        underrun_reg;

    logic        load;
    logic        xfer;
    logic        slot_first;
    logic        in_preamble;
    logic [23:0] cur_sample;
    logic        cs_bit;
    logic        parity;
    logic [31:0] slot_vec;
    logic        data_bit;
    logic [7:0]  pre_pat;
    logic [2:0]  pre_idx;
    logic        pre_inv;
    logic        line_next;

    assign run       = resetb & tx_enable;
    assign nco_clear = ~run;

    spdif_nco #(
        .ACC_W     (ACC_W),
        .PHASE_INC (PHASE_INC)
    ) u_nco (
        .clk_in (clk_in),
        .clear  (nco_clear),
        .tick   (tick)
    );

    assign load        = sample_valid & ~hold_full_reg;
    assign slot_first  = (slot_reg == 5'd0) & ~cell_reg;
    assign xfer        = tick & slot_first & (sub_reg == SUB_L);
    assign in_preamble = (slot_reg[4:2] == 3'd0);

    assign cur_sample = (sub_reg == SUB_R) ? r_reg : l_reg;
    assign cs_bit     = (frame_reg < 8'd40) & CS_EXT[frame_reg[5:0]];
    // U is always 0, so it drops out of the parity sum
    assign parity     = ^{cur_sample, v_reg, cs_bit};

    assign slot_vec[SLOT_AUX0-1:0] = '0;
    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_audio_slot
            assign slot_vec[SLOT_AUX0+gi] = cur_sample[gi];
        end
    endgenerate
    assign slot_vec[SLOT_V] = v_reg;
    assign slot_vec[SLOT_U] = 1'b0;
    assign slot_vec[SLOT_C] = cs_bit;
    assign slot_vec[SLOT_P] = parity;

    assign data_bit = slot_vec[slot_reg];

    // Preamble polarity is chosen from the line level just before slot 0 and held for all 8 cells
    assign pre_pat = preamble_for(sub_reg, frame_reg == 8'd0);
    assign pre_idx = {slot_reg[1:0], cell_reg};
    assign pre_inv = slot_first ? tx_out_reg : pre_inv_reg;

    always_comb begin
        line_next = tx_out_reg;
        if (in_preamble) begin
            line_next = pre_pat[3'd7 - pre_idx] ^ pre_inv;
        end else if (!cell_reg) begin
            line_next = ~tx_out_reg;
        end else begin
            line_next = tx_out_reg ^ data_bit;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            hold_full_reg <= 1'b0;
            hold_l_reg    <= '0;
            hold_r_reg    <= '0;
        end else if (load) begin
            hold_full_reg <= 1'b1;
            hold_l_reg    <= sample_l;
            hold_r_reg    <= sample_r;
        end else if (xfer) begin
            hold_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!run) begin
            cell_reg        <= 1'b0;
            slot_reg        <= '0;
            sub_reg         <= SUB_L;
            frame_reg       <= '0;
            tx_out_reg      <= 1'b0;
            pre_inv_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            l_reg           <= '0;
            r_reg           <= '0;
            v_reg           <= 1'b0;
        end else begin
            frame_start_reg <= xfer;
            underrun_reg    <= xfer & ~hold_full_reg;
            if (tick) begin
                tx_out_reg <= line_next;
                cell_reg   <= ~cell_reg;
                if (slot_first) begin
                    pre_inv_reg <= tx_out_reg;
                end
                if (cell_reg) begin
                    slot_reg <= slot_reg + 5'd1;
                    if (slot_reg == 5'(SLOT_P)) begin
                        sub_reg <= (sub_reg == SUB_L) ? SUB_R : SUB_L;
                        if (sub_reg == SUB_R) begin
                            frame_reg <= (frame_reg == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_reg + 8'd1;
                        end
                    end
                end
                if (xfer) begin
                    l_reg <= hold_full_reg ? hold_l_reg : 24'd0;
                    r_reg <= hold_full_reg ? hold_r_reg : 24'd0;
                    v_reg <= ~hold_full_reg;
                end
            end
        end
    end

    assign sample_ready = ~hold_full_reg;
    assign tx_out       = tx_out_reg;
    assign frame_start  = frame_start_reg;
    assign underrun     = underrun_reg;

endmodule
